// File: rtl/hilo_pkg.sv
// Shared width, command encodings and controller states for the HI/LO unit.
package hilo_pkg;

   localparam int unsigned WIDTH = 16;

   localparam logic [2:0] OpNop  = 3'b000;
   localparam logic [2:0] OpMult = 3'b001;
   localparam logic [2:0] OpDiv  = 3'b010;
   localparam logic [2:0] OpMfhi = 3'b011;
   localparam logic [2:0] OpMflo = 3'b100;
   localparam logic [2:0] OpMthi = 3'b101;
   localparam logic [2:0] OpMtlo = 3'b110;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StMWait  = 2'd1;
   localparam logic [1:0] StDivide = 2'd2;

endpackage

// File: rtl/hilo_unit_if.sv
// Command, multiplier and status signals of the HI/LO unit.
interface hilo_unit_if;
   import hilo_pkg::*;

   logic [2:0]       OP;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             MULT_EN;
   logic [WIDTH-1:0] MULT_HI;
   logic [WIDTH-1:0] MULT_LO;
   logic [WIDTH-1:0] RDATA;
   logic             BUSY;
   logic             DIV0;

   modport master (
      output OP, A, B, MULT_HI, MULT_LO,
      input  MULT_EN, RDATA, BUSY, DIV0
   );

   modport slave (
      input  OP, A, B, MULT_HI, MULT_LO,
      output MULT_EN, RDATA, BUSY, DIV0
   );

endinterface

// File: rtl/hilo_unit_div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// quotient/remainder carry the final step's result while done is high.
module div_iter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
   logic [CntW-1:0]  cnt_q;
   logic             run_q;

   logic [WIDTH:0]   rem_sh;
   logic             fits;
   logic [WIDTH-1:0] rem_nx, quo_nx;

   // A zero divisor always fits, so the quotient fills with ones and the
   // dividend shifts straight through into the remainder.
   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      fits   = (rem_sh >= {1'b0, dsr_q});
      rem_nx = fits ? (rem_sh[WIDTH-1:0] - dsr_q) : rem_sh[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], fits};
   end

   assign done      = run_q && (cnt_q == CntW'(WIDTH - 1));
   assign quotient  = quo_nx;
   assign remainder = rem_nx;

   always_ff @(posedge CLK) begin
      if (RST) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dsr_q <= '0;
      end else if (start) begin
         run_q <= 1'b1;
         cnt_q <= '0;
         quo_q <= dividend;
         rem_q <= '0;
         dsr_q <= divisor;
      end else if (run_q) begin
         quo_q <= quo_nx;
         rem_q <= rem_nx;
         cnt_q <= cnt_q + 1'b1;
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: external multiplier handshake, iterative divider,
// and move-to/move-from access to the HI and LO registers.
module hilo_unit #(
   parameter int unsigned WIDTH = hilo_pkg::WIDTH
) (
   input logic        CLK,
   input logic        RST,
   hilo_unit_if.slave bus
);
   import hilo_pkg::*;

   logic [1:0]       state_q;
   logic [WIDTH-1:0] hi_q, lo_q, rdata_q;
   logic             div0_q, div0_pend_q;

   logic             accept, div_start, div_done;
   logic [WIDTH-1:0] div_quo, div_rem;

   assign accept    = (state_q == StIdle) && !RST;
   assign div_start = accept && (bus.OP == OpDiv);

   assign bus.MULT_EN = accept && (bus.OP == OpMult);
   assign bus.RDATA   = rdata_q;
   assign bus.BUSY    = (state_q != StIdle);
   assign bus.DIV0    = div0_q;

   div_iter #(
      .WIDTH (WIDTH)
   ) u_div (
      .CLK       (CLK),
      .RST       (RST),
      .start     (div_start),
      .dividend  (bus.A),
      .divisor   (bus.B),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         hi_q        <= '0;
         lo_q        <= '0;
         rdata_q     <= '0;
         div0_q      <= 1'b0;
         div0_pend_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               case (bus.OP)
                  OpMult: state_q <= StMWait;
                  OpDiv: begin
                     state_q     <= StDivide;
                     div0_pend_q <= (bus.B == '0);
                  end
                  OpMfhi: rdata_q <= hi_q;
                  OpMflo: rdata_q <= lo_q;
                  OpMthi: hi_q    <= bus.A;
                  OpMtlo: lo_q    <= bus.A;
                  default: ;
               endcase
            end
            // Multiplier registered its product at the issue edge.
            StMWait: begin
               hi_q    <= bus.MULT_HI;
               lo_q    <= bus.MULT_LO;
               state_q <= StIdle;
            end
            StDivide: begin
               if (div_done) begin
                  lo_q    <= div_quo;
                  hi_q    <= div_rem;
                  div0_q  <= div0_pend_q;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: arithmetic reference model, external
// multiplier model, and a monitor that checks every MFHI/MFLO read.
module tb_hilo_unit;
   import hilo_pkg::*;

   logic CLK;
   logic RST;

   hilo_unit_if bus ();

   hilo_unit #(
      .WIDTH (16)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // External registered multiplier.
   always @(posedge CLK) begin
      if (bus.MULT_EN) {bus.MULT_HI, bus.MULT_LO} <= 32'(bus.A) * 32'(bus.B);
   end

   int checks = 0;
   int errors = 0;
   int mult_en_cnt = 0;
   int exp_mults = 0;

   logic [15:0] hi_m, lo_m;
   logic        div0_m;
   logic [15:0] exp_q[$];

   always @(posedge CLK) begin
      if (bus.MULT_EN) mult_en_cnt <= mult_en_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Read monitor: an accepted MFHI/MFLO must update RDATA at that edge.
   initial begin
      logic        rd;
      logic [15:0] exp;
      forever begin
         @(negedge CLK);
         #2;
         rd = !RST && !bus.BUSY && (bus.OP == OpMfhi || bus.OP == OpMflo);
         @(posedge CLK);
         #1;
         if (rd) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rdata_unexpected actual=%h expected=no read", bus.RDATA);
            end else begin
               exp = exp_q.pop_front();
               check("rdata", 32'(bus.RDATA), 32'(exp));
            end
         end
      end
   end

   // Mode 0: idle bus while busy; 1: random commands; 2: MTLO/MFLO 0x5555
   // with RDATA required to hold.
   task automatic wait_idle(input int mode, output int cyc);
      logic [15:0] hold;
      hold = bus.RDATA;
      cyc  = 0;
      while (bus.BUSY && cyc < 64) begin
         cyc++;
         if (mode == 2) begin
            check("rdata_hold", 32'(bus.RDATA), 32'(hold));
            bus.OP = cyc[0] ? OpMtlo : OpMflo;
            bus.A  = 16'h5555;
         end else if (mode == 1) begin
            bus.OP = 3'($urandom_range(0, 7));
            bus.A  = 16'($urandom);
            bus.B  = 16'($urandom);
         end
         @(negedge CLK);
      end
      if (bus.BUSY) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout actual=1 expected=0 t=%0t", $time);
      end
      bus.OP = OpNop;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int mode);
      int          cyc;
      logic [31:0] prod;
      bus.OP = op;
      bus.A  = a;
      bus.B  = b;
      #1;
      check("mult_en", 32'(bus.MULT_EN), 32'(op == OpMult));
      case (op)
         OpMult: begin
            prod = 32'(a) * 32'(b);
            hi_m = prod[31:16];
            lo_m = prod[15:0];
            exp_mults++;
         end
         OpDiv: begin
            if (b == 16'h0) begin
               lo_m   = 16'hFFFF;
               hi_m   = a;
               div0_m = 1'b1;
            end else begin
               lo_m   = a / b;
               hi_m   = a % b;
               div0_m = 1'b0;
            end
         end
         OpMfhi: exp_q.push_back(hi_m);
         OpMflo: exp_q.push_back(lo_m);
         OpMthi: hi_m = a;
         OpMtlo: lo_m = a;
         default: ;
      endcase
      @(negedge CLK);
      bus.OP = OpNop;
      bus.A  = 16'($urandom);
      bus.B  = 16'($urandom);
      wait_idle(mode, cyc);
      check("busy_cycles", 32'(cyc), (op == OpMult) ? 32'd1 : (op == OpDiv) ? 32'd16 : 32'd0);
      if (op == OpDiv) check("div0", 32'(bus.DIV0), 32'(div0_m));
   endtask

   task automatic read_both();
      do_op(OpMfhi, 16'h0, 16'h0, 0);
      do_op(OpMflo, 16'h0, 16'h0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a, b;
      RST    = 1'b1;
      bus.OP = OpMult;
      bus.A  = 16'h1234;
      bus.B  = 16'h0100;
      hi_m   = 16'h0;
      lo_m   = 16'h0;
      div0_m = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      check("rst_mult_en", 32'(bus.MULT_EN), 32'd0);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_rdata", 32'(bus.RDATA), 32'd0);
      check("rst_div0", 32'(bus.DIV0), 32'd0);
      RST    = 1'b0;
      bus.OP = OpNop;
      read_both();

      do_op(OpMult, 16'h1234, 16'h0100, 0);
      read_both();
      do_op(OpDiv, 16'd100, 16'd7, 1);
      read_both();
      do_op(OpDiv, 16'h8000, 16'h0, 1);
      read_both();
      do_op(OpDiv, 16'd9, 16'd3, 0);
      read_both();
      do_op(OpDiv, 16'd100, 16'd7, 2);
      do_op(OpMflo, 16'h0, 16'h0, 0);
      do_op(OpMthi, 16'hBEEF, 16'h0, 0);
      do_op(OpMfhi, 16'h0, 16'h0, 0);
      do_op(OpMult, 16'hFFFF, 16'hFFFF, 0);
      read_both();

      // Reset in the eighth divide iteration discards the pending result.
      do_op(OpMthi, 16'hBEEF, 16'h0, 0);
      bus.OP = OpDiv;
      bus.A  = 16'd1000;
      bus.B  = 16'd3;
      @(negedge CLK);
      bus.OP = OpNop;
      repeat (7) @(negedge CLK);
      check("busy_iter8", 32'(bus.BUSY), 32'd1);
      RST    = 1'b1;
      bus.OP = OpMult;
      #1;
      check("rst_gates_mult_en", 32'(bus.MULT_EN), 32'd0);
      @(negedge CLK);
      RST    = 1'b0;
      bus.OP = OpNop;
      check("abort_busy", 32'(bus.BUSY), 32'd0);
      check("abort_rdata", 32'(bus.RDATA), 32'd0);
      check("abort_div0", 32'(bus.DIV0), 32'd0);
      hi_m   = 16'h0;
      lo_m   = 16'h0;
      div0_m = 1'b0;
      read_both();

      for (int i = 0; i < 80; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 5) == 0) ? 16'h0 :
             ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 40)) : 16'($urandom);
         do_op(3'($urandom_range(0, 7)), a, b, 1);
         if ($urandom_range(0, 3) == 0) read_both();
      end
      read_both();

      repeat (3) @(negedge CLK);
      check("mult_en_pulses", 32'(mult_en_cnt), 32'(exp_mults));
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; the unit SHALL be built and verified at 16 only.
REQ-002 Clocking: one clock CLK; reset RST is synchronous and active-high.
REQ-003 CLK  input  1  sole clock; all state updates on posedge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 OP  input  3  command: 000 NOP, 001 MULT, 010 DIV, 011 MFHI, 100 MFLO, 101 MTHI, 110 MTLO, 111 NOP.
REQ-006 A  input  16  MULT multiplicand / DIV dividend / MTHI-MTLO write data.
REQ-007 B  input  16  MULT multiplier / DIV divisor.
REQ-008 MULT_EN  output  1  enable to the downstream-registered multiplier; high only in the MULT issue cycle.
REQ-009 MULT_HI  input  16  multiplier registered high product half.
REQ-010 MULT_LO  input  16  multiplier registered low product half.
REQ-011 RDATA  output  16  registered MFHI/MFLO read data.
REQ-012 BUSY  output  1  registered; high while a MULT or DIV result is pending.
REQ-013 DIV0  output  1  registered; divide-by-zero status of the last completed DIV.

Function
REQ-014 States: IDLE, MWAIT, DIVIDE; OP SHALL be accepted only in IDLE, and any OP while BUSY=1 SHALL have no effect.
REQ-015 MULT issued in IDLE at cycle n: MULT_EN=1 combinationally in cycle n; IDLE->MWAIT; BUSY=1 in cycle n+1; at the edge ending n+1, HI<=MULT_HI, LO<=MULT_LO; MWAIT->IDLE.
REQ-016 MULT is unsigned, 16x16->32; the unit SHALL not alter the product halves.
REQ-017 DIV issued at cycle n: operands latched at edge ending n; IDLE->DIVIDE; 16 radix-2 restoring iterations in cycles n+1..n+16; BUSY=1 throughout; at edge ending n+16, LO<=quotient, HI<=remainder, DIVIDE->IDLE.
REQ-018 DIV is unsigned; a changing A/B after issue SHALL not affect the result.
REQ-019 Divide by zero: same 16-cycle latency; LO<=0xFFFF, HI<=dividend, DIV0<=1; any nonzero-divisor DIV completion SHALL clear DIV0.
REQ-020 MFHI/MFLO in IDLE at cycle n: RDATA<=HI/LO at edge ending n; RDATA SHALL hold its value otherwise.
REQ-021 MTHI/MTLO in IDLE: HI/LO<=A at that edge; a MFHI/MFLO in the next cycle SHALL return the new value.
REQ-022 Back-to-back: a new OP SHALL be accepted in the first cycle BUSY=0 after completion, and HI/LO written at the preceding edge SHALL be visible to it.
REQ-023 HI/LO SHALL change only on MULT/DIV completion, MTHI/MTLO, or reset.

Reset
REQ-024 RST=1 at a posedge SHALL force state IDLE and HI, LO, RDATA = 0, and BUSY, DIV0 = 0, with MULT_EN=0 while RST=1.
REQ-025 Reset during MWAIT or DIVIDE SHALL abort the operation with no partial HI/LO update; OP is ignored in any cycle with RST=1.

Structure
REQ-026 Package hilo_pkg SHALL hold WIDTH, OP encodings, and the state enumeration.
REQ-027 The iterative divide datapath SHALL be one sub-module, div_iter (start, dividend, divisor, quotient, remainder, done), instantiated once.
REQ-028 The multiplier SHALL remain external; the unit connects only through MULT_EN/MULT_HI/MULT_LO.

Verification
REQ-029 MULT A=0x1234 B=0x0100 -> MULT_EN pulse 1 cycle, BUSY 1 cycle; MFHI->0x0012, MFLO->0x3400.
REQ-030 DIV A=100 B=7 -> BUSY exactly 16 cycles; LO=14, HI=2, DIV0=0.
REQ-031 DIV A=0x8000 B=0 -> after 16 cycles LO=0xFFFF, HI=0x8000, DIV0=1; next DIV 9/3 -> LO=3, HI=0, DIV0=0.
REQ-032 MTLO 0x5555 issued during DIV 100/7 BUSY -> ignored; LO=14 after completion; RDATA unchanged during BUSY.
REQ-033 RST at DIVIDE iteration 8 after MTHI 0xBEEF -> next cycle BUSY=0, HI=LO=0; MFHI->0x0000.
REQ-034 MTHI 0xBEEF then MFHI next cycle -> RDATA=0xBEEF; MULT 0xFFFF*0xFFFF then MFHI/MFLO -> 0xFFFE/0x0001.
